// File: rtl/dw_pe_array.sv
// dw_pe_array: POY x POX depthwise MAC array accumulating KSIZE*KSIZE taps per window,
// with a one-deep valid/ready tile holding register and a sticky overrun flag.
module dw_pe_array #(
    parameter int DW    = 32,
    parameter int POY   = 3,
    parameter int POX   = 16,
    parameter int KSIZE = 3,
    parameter int TW    = 4,
    parameter int ACCW  = 68
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   dwpe_ena,
    input  logic                   blkend,
    input  logic signed [DW-1:0]   pixel_array [POY][POX],
    input  logic signed [DW-1:0]   weight,
    output logic [TW-1:0]          tap_idx,
    output logic signed [ACCW-1:0] psum_array [POY][POX],
    output logic                   psum_valid,
    input  logic                   psum_ready,
    output logic                   overrun,
    input  logic                   overrun_clr
);
    localparam int NTAP = KSIZE * KSIZE;
    typedef enum logic {IDLE, RUN} acc_st_e;
    typedef enum logic {EMPTY, FULL} out_st_e;
    acc_st_e acc_st_q, acc_st_d;
    out_st_e out_st_q, out_st_d;
    logic [TW-1:0] tap_q, tap_d;
    logic overrun_q, overrun_d;
    logic complete, acc_clr, acc_load, tile_load, drop;
    logic signed [ACCW-1:0] w_ext;
    assign w_ext = ACCW'(weight);
    // Completion outranks blkend so a finished window is never lost to an abort.
    always_comb begin
        complete  = dwpe_ena && (NTAP == 1 || (acc_st_q == RUN && tap_q == TW'(NTAP - 1)));
        acc_clr   = complete || blkend;
        acc_load  = dwpe_ena && !acc_clr;
        acc_st_d  = acc_clr ? IDLE : dwpe_ena ? RUN : acc_st_q;
        tap_d     = acc_clr ? '0 : dwpe_ena ? tap_q + 1'b1 : tap_q;
        tile_load = complete && (out_st_q == EMPTY || psum_ready);
        drop      = complete && out_st_q == FULL && !psum_ready;
        out_st_d  = tile_load ? FULL : (out_st_q == FULL && psum_ready) ? EMPTY : out_st_q;
        overrun_d = drop || (overrun_q && !overrun_clr);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_st_q  <= IDLE;
            out_st_q  <= EMPTY;
            tap_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            acc_st_q  <= acc_st_d;
            out_st_q  <= out_st_d;
            tap_q     <= tap_d;
            overrun_q <= overrun_d;
        end
    end
    for (genvar y = 0; y < POY; y++) begin : g_row
        for (genvar x = 0; x < POX; x++) begin : g_col
            logic signed [ACCW-1:0] acc_q, psum_q, prod, sum;
            assign prod = ACCW'(pixel_array[y][x]) * w_ext;
            // The first tap of a window replaces the accumulator instead of adding to it.
            assign sum = ((acc_st_q == RUN) ? acc_q : '0) + prod;
            assign psum_array[y][x] = psum_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_q  <= '0;
                    psum_q <= '0;
                end else begin
                    if (acc_clr) acc_q <= '0;
                    else if (acc_load) acc_q <= sum;
                    if (tile_load) psum_q <= sum;
                end
            end
        end
    end
    assign tap_idx    = tap_q;
    assign psum_valid = (out_st_q == FULL);
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_dw_pe_array.sv
// tb_dw_pe_array: directed checks of the depthwise PE array with hand-computed tiles.
module tb_dw_pe_array;
    logic clk = 1'b0, rst = 1'b1, dwpe_ena = 1'b0, blkend = 1'b0;
    logic psum_ready = 1'b0, overrun_clr = 1'b0;
    logic signed [31:0] pix [3][16];
    logic signed [31:0] weight = '0;
    logic [3:0] tap_idx;
    logic signed [67:0] psum [3][16];
    logic psum_valid, overrun;
    int n_assert = 0, n_fail = 0;
    int wv [9];
    dw_pe_array dut (
        .clk(clk), .rst(rst), .dwpe_ena(dwpe_ena), .blkend(blkend),
        .pixel_array(pix), .weight(weight), .tap_idx(tap_idx),
        .psum_array(psum), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic chk_tile(input string tag, input logic signed [67:0] base, input bit by_idx);
        int bad = 0;
        logic signed [67:0] e, o_bad = '0, e_bad = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 16; x++) begin
                e = by_idx ? base * (y * 16 + x) : base;
                if (psum[y][x] !== e) begin
                    if (bad == 0) begin o_bad = psum[y][x]; e_bad = e; end
                    bad++;
                end
            end
        n_assert++;
        assert (bad == 0) else begin
            n_fail++;
            $error("FAIL %s: %0d PEs wrong, first observed %0h expected %0h", tag, bad, o_bad, e_bad);
        end
    endtask
    task automatic set_pix(input int v, input bit by_idx);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 16; x++)
                pix[y][x] = by_idx ? v * (y * 16 + x) : v;
    endtask
    // Present taps 0..n-1 with optional idle gaps; extras apply only on the last tap.
    task automatic run_win(input int n, input int gap, input bit chk_tap,
                           input bit blk_last, input bit clr_last, input bit rdy_last);
        logic rdy_save;
        rdy_save = psum_ready;
        for (int t = 0; t < n; t++) begin
            if (chk_tap) chk("tap_idx_seq", tap_idx, t);
            if (chk_tap && t == n - 1) chk("valid_before_last", psum_valid, 0);
            weight = wv[t];
            dwpe_ena = 1'b1;
            if (t == n - 1) begin
                blkend = blk_last;
                overrun_clr = clr_last;
                if (rdy_last) psum_ready = 1'b1;
            end
            tick();
            dwpe_ena = 1'b0;
            blkend = 1'b0;
            overrun_clr = 1'b0;
            psum_ready = rdy_save;
            if (t < n - 1)
                for (int g = 0; g < gap; g++) tick();
        end
    endtask
    initial begin
        set_pix(0, 0);
        #2;
        chk("reset_tap", tap_idx, 0);
        chk("reset_valid", psum_valid, 0);
        chk("reset_overrun", overrun, 0);
        chk_tile("reset_tile", 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        // Single window, ones times 1..9
        psum_ready = 1'b1;
        set_pix(1, 0);
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_win(9, 0, 1, 0, 0, 0);
        chk("w1_valid", psum_valid, 1);
        chk("w1_tap_wrap", tap_idx, 0);
        chk_tile("w1_tile45", 45, 0);
        tick();
        chk("w1_valid_one_cycle", psum_valid, 0);
        // Signed windows
        set_pix(-2, 0);
        wv = '{3, 3, 3, 3, 3, 3, 3, 3, 3};
        run_win(9, 0, 0, 0, 0, 0);
        chk("neg_valid", psum_valid, 1);
        chk_tile("neg_tile_m54", -54, 0);
        tick();
        set_pix(32'sh8000_0000, 0);
        wv = '{32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000,
               32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000};
        run_win(9, 0, 0, 0, 0, 0);
        chk_tile("corner_9x2p62", 68'sd9 << 62, 0);
        tick();
        // Gapped partial window aborted by blkend (with a coincident tap)
        set_pix(1, 0);
        wv = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run_win(5, 2, 1, 0, 0, 0);
        chk("abort_tap_before", tap_idx, 5);
        blkend = 1'b1;
        dwpe_ena = 1'b1;
        weight = 100;
        tick();
        blkend = 1'b0;
        dwpe_ena = 1'b0;
        chk("abort_tap_cleared", tap_idx, 0);
        chk("abort_no_valid", psum_valid, 0);
        chk("abort_no_overrun", overrun, 0);
        set_pix(1, 1);
        run_win(9, 1, 1, 0, 0, 0);
        chk("fresh_valid", psum_valid, 1);
        chk_tile("fresh_tile_45idx", 45, 1);
        tick();
        // Back-pressure: drop, sticky overrun, clear, clear colliding with drop
        psum_ready = 1'b0;
        set_pix(1, 0);
        run_win(9, 0, 0, 0, 0, 0);
        set_pix(2, 0);
        run_win(9, 0, 0, 0, 0, 0);
        chk("bp_valid", psum_valid, 1);
        chk_tile("bp_old_tile_kept", 45, 0);
        chk("bp_overrun", overrun, 1);
        tick();
        chk("bp_overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("bp_overrun_cleared", overrun, 0);
        set_pix(5, 0);
        run_win(9, 0, 0, 0, 1, 0);
        chk("bp_set_wins_clear", overrun, 1);
        chk_tile("bp_tile_still_old", 45, 0);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        psum_ready = 1'b1;
        tick();
        chk("bp_drained", psum_valid, 0);
        chk("bp_overrun_zero", overrun, 0);
        // Handover and completion in the same cycle
        psum_ready = 1'b0;
        set_pix(1, 0);
        run_win(9, 0, 0, 0, 0, 0);
        set_pix(3, 0);
        run_win(9, 0, 0, 0, 0, 1);
        chk("swap_valid", psum_valid, 1);
        chk_tile("swap_tile135", 135, 0);
        chk("swap_no_overrun", overrun, 0);
        psum_ready = 1'b1;
        tick();
        chk("swap_drained", psum_valid, 0);
        // blkend with the completing tap still completes
        set_pix(1, 0);
        run_win(9, 0, 0, 1, 0, 0);
        chk("blklast_valid", psum_valid, 1);
        chk_tile("blklast_tile45", 45, 0);
        chk("blklast_tap", tap_idx, 0);
        tick();
        // Async reset mid-window
        run_win(5, 0, 0, 0, 0, 0);
        dwpe_ena = 1'b1;
        weight = 6;
        rst = 1'b1;
        #1;
        chk("rst_mid_tap", tap_idx, 0);
        dwpe_ena = 1'b0;
        tick();
        rst = 1'b0;
        // Async reset while FULL with overrun set
        psum_ready = 1'b0;
        run_win(9, 0, 0, 0, 0, 0);
        run_win(9, 0, 0, 0, 0, 0);
        chk("pre_rst_overrun", overrun, 1);
        rst = 1'b1;
        #1;
        chk("rst_full_valid", psum_valid, 0);
        chk("rst_full_overrun", overrun, 0);
        chk_tile("rst_full_tile", 0, 0);
        tick();
        rst = 1'b0;
        psum_ready = 1'b1;
        set_pix(1, 1);
        wv = '{2, 2, 2, 2, 2, 2, 2, 2, 2};
        run_win(9, 0, 1, 0, 0, 0);
        chk("post_rst_valid", psum_valid, 1);
        chk_tile("post_rst_tile_18idx", 18, 1);
        tick();
        chk("post_rst_drained", psum_valid, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dw_pe_array.md
Name: dw_pe_array

Overview:
- Depthwise-convolution MAC array directly downstream of the data router; consumes its POY x POX pixel window stream plus the dwpe_ena qualifier.
- Each PE multiplies its pixel by one shared per-tap weight and accumulates over KSIZE*KSIZE taps.
- Presents the finished POY x POX partial-sum tile to the output writer through a valid/ready holding register.
- Flags any tile lost to output back-pressure with a sticky overrun bit, because the router stream cannot be stalled.

Parameters:
- DW, 32, signed pixel and weight width.
- POY, 3, PE rows (output rows per tile).
- POX, 16, PE columns (output columns per tile).
- KSIZE, 3, kernel edge; taps per window NTAP = KSIZE*KSIZE.
- TW, 4, tap counter width, must satisfy 2^TW >= NTAP.
- ACCW, 68, accumulator width, 2*DW + TW; no saturation needed.

Ports:
- clk  in  1  clock, all state rising-edge.
- rst  in  1  asynchronous active-high reset.
- dwpe_ena  in  1  pixel_array and weight valid this cycle; consume one tap.
- blkend  in  1  block boundary; aborts any partially accumulated window.
- pixel_array  in  DW x [POY][POX]  signed pixels from the data router.
- weight  in  DW  signed weight for tap tap_idx, valid with dwpe_ena.
- tap_idx  out  TW  current tap number, used as the weight-buffer address.
- psum_array  out  ACCW x [POY][POX]  finished tile, held while psum_valid.
- psum_valid  out  1  tile available.
- psum_ready  in  1  consumer accepts the tile when psum_valid && psum_ready.
- overrun  out  1  sticky: a completed tile was dropped.
- overrun_clr  in  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert, sync release) sets: tap_idx=0, acc=0, psum_array=0, psum_valid=0, overrun=0, accumulator state IDLE, output state EMPTY.
- Arithmetic: prod = signed(pixel) * signed(weight), sign-extended to ACCW. Accumulation is exact two's-complement.
- Accumulator FSM, states IDLE and RUN:
  - IDLE with dwpe_ena: acc = prod (no add), tap_idx -> 1, go to RUN. When NTAP==1, complete immediately instead.
  - RUN with dwpe_ena and tap_idx < NTAP-1: acc += prod, tap_idx++.
  - RUN with dwpe_ena and tap_idx == NTAP-1: tile = acc + prod, tap_idx -> 0, go to IDLE, raise a one-cycle internal complete.
  - No dwpe_ena: hold everything. Gaps between taps are legal.
- blkend: at the clock edge, tap_idx -> 0, acc -> 0, state -> IDLE. Any partial window is discarded with no output and no overrun.
  - blkend together with dwpe_ena: the blkend clear wins and the tap is discarded.
  - blkend together with a completing tap: the tile still completes (completion takes priority over abort).
- Latency: psum_valid rises on the edge that samples the last tap's dwpe_ena, i.e. the cycle after that tap is presented.
- Output stage, states EMPTY and FULL:
  - complete in EMPTY: load tile, go to FULL (psum_valid=1).
  - FULL with psum_valid && psum_ready, no complete: go to EMPTY.
  - FULL with psum_ready and complete in the same cycle: load the new tile, stay FULL. Not an overrun.
  - FULL with !psum_ready and complete: keep the old tile, drop the new one, set overrun.
  - psum_array is stable while FULL and not handed over.
- overrun: stays set until overrun_clr. If overrun_clr coincides with a new drop, overrun stays 1 (set wins).
- tap_idx is registered. weight must correspond to tap_idx in the cycle dwpe_ena is high.

Test Plan:
- Single window with all pixels=1 and weights 1..9 over 9 consecutive ena cycles, psum_ready=1 -> psum_valid for exactly 1 cycle, one cycle after the 9th tap; every PE = 45; tap_idx sequence 0..8,0.
- Signed window with pixels=-2 (0xFFFFFFFE), weights=3, 9 taps -> every PE = -54 sign-extended to 68 bits; corner value pixel=weight=-2^31 -> 9*2^62 with no wrap.
- Taps spread with 2-cycle ena gaps, then blkend asserted after tap 4 -> no psum_valid, tap_idx=0; the next full window yields the correct fresh sum, unaffected by the discarded taps.
- psum_ready held low, two windows complete -> first tile retained unchanged, overrun=1; overrun_clr pulse -> overrun=0.
- Tile FULL, psum_ready=1 in the same cycle the next window completes -> new tile loaded, psum_valid stays 1, overrun=0.
- rst asserted mid-window (tap 5) and while FULL -> all outputs 0 asynchronously; after release, a fresh 9-tap window produces the correct result.
